mul_div_ctrl: RTL

- Multi-cycle multiply/divide sequencer beside the EX stage.
- Accepts a MULT/MULTU/DIV/DIVU request and iterates a shift-add multiplier or restoring divider over WIDTH cycles.
- Holds the pipeline with stall_req while it works, then writes the architectural HI/LO registers.
- Also services MTHI/MTLO writes and supplies HI/LO to EX for MFHI/MFLO.

---
 rtl/mul_div_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one step per cycle over WIDTH cycles.
module mul_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_1,
    input  logic [WIDTH-1:0] i_operand_2,
    input  logic             i_flush,
    input  logic             i_hi_wen,
    input  logic             i_lo_wen,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_stall_req,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_accept;
    logic               w_div_zero;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Operand magnitudes and sign flags; op[0]=0 selects the signed variants.
    assign w_signed   = ~i_op[0];
    assign w_sign_a   = w_signed & i_operand_1[WIDTH-1];
    assign w_sign_b   = w_signed & i_operand_2[WIDTH-1];
    assign w_mag_a    = w_sign_a ? (-i_operand_1) : i_operand_1;
    assign w_mag_b    = w_sign_b ? (-i_operand_2) : i_operand_2;
    assign w_accept   = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_div_zero = i_op[1] && (i_operand_2 == {WIDTH{1'b0}});

    // Multiply step: low half holds the remaining multiplier bits, product shifts in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? (-w_mul_next) : w_mul_next;

    // Divide step: upper half is the partial remainder, lower half dividend bits turning into quotient.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};
    assign w_quot      = r_neg_q ? (-w_div_next[WIDTH-1:0]) : w_div_next[WIDTH-1:0];
    assign w_rem       = r_neg_r ? (-w_div_next[2*WIDTH-1:WIDTH]) : w_div_next[2*WIDTH-1:WIDTH];

    assign o_stall_req = w_accept || r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;

    // Sequencer FSM, datapath registers and HI/LO write-back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_acc   <= {(2*WIDTH){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_cnt   <= {CW{1'b0}};
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        if (w_div_zero) begin
                            r_hi    <= i_operand_1;
                            r_lo    <= {WIDTH{1'b1}};
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (i_op[1]) begin
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                            r_state <= S_DIV;
                            r_busy  <= 1'b1;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        if (i_hi_wen) r_hi <= i_wdata;
                        if (i_lo_wen) r_lo <= i_wdata;
                    end
                end
                S_MUL, S_DIV: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_state == S_MUL) begin
                                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                                r_lo <= w_prod[WIDTH-1:0];
                            end else begin
                                r_hi <= w_rem;
                                r_lo <= w_quot;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // start is ignored here so the finishing instruction cannot retrigger.
                    r_state <= S_IDLE;
                    if (!i_flush) begin
                        if (i_hi_wen) r_hi <= i_wdata;
                        if (i_lo_wen) r_lo <= i_wdata;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
